fwd_scoreboard: RTL

- Parametrised forwarding scoreboard for the pipelined core. Replaces the fixed three-tag execute/access/writeback forwarding bundle with an owned, shifting N-slot tag pipeline.
- Tracks in-flight register writes and resolves late (memory) data in place.
- Supplies forwarded operands or a stall per read port to decode, and drives the register-file write port from the oldest slot.

---
 rtl/fwd_scoreboard_pkg.sv | 25 ++
 rtl/fwd_scoreboard_if.sv | 52 +++++
 rtl/fwd_scoreboard_port_lookup.sv | 66 ++++++
 rtl/fwd_scoreboard.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg
//   Shared types for the forwarding scoreboard.
//   - fwd_slot_t       : one tracked in-flight register write at the default
//                        core widths (5-bit address, 32-bit data).
//   - fwd_lookup_e     : outcome of a single read-port search.
package fwd_scoreboard_pkg;

    localparam int FWD_DEF_ADDR_WIDTH = 5;
    localparam int FWD_DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic                          occupied;
        logic [FWD_DEF_ADDR_WIDTH-1:0] addr;
        logic [FWD_DEF_DATA_WIDTH-1:0] data;
        logic                          data_valid;
    } fwd_slot_t;

    typedef enum logic [1:0] {
        LK_MISS   = 2'd0,  // no in-flight writer, use register file
        LK_HIT    = 2'd1,  // writer has final data
        LK_BYPASS = 2'd2,  // writer is being resolved this cycle
        LK_PEND   = 2'd3   // writer exists but data not yet known
    } fwd_lookup_e;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if
//   Bundle between the pipeline control / decode stage (master) and the
//   forwarding scoreboard (slave).
//   master drives : advance, flush, issue_*, resolve_*, rd_addr, rd_reg_data,
//                   stall_cnt_clr
//   slave drives  : rd_data, rd_stall, stall, wb_we, wb_addr, wb_data,
//                   stall_cycles
interface fwd_scoreboard_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int CNT_WIDTH      = 16
) ();

    logic                                          advance;
    logic                                          flush;
    logic                                          issue_valid;
    logic [ADDR_WIDTH-1:0]                         issue_addr;
    logic [DATA_WIDTH-1:0]                         issue_data;
    logic                                          issue_data_valid;
    logic                                          resolve_valid;
    logic [DATA_WIDTH-1:0]                         resolve_data;
    logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]     rd_addr;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]     rd_reg_data;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]     rd_data;
    logic [NUM_READ_PORTS-1:0]                     rd_stall;
    logic                                          stall;
    logic                                          wb_we;
    logic [ADDR_WIDTH-1:0]                         wb_addr;
    logic [DATA_WIDTH-1:0]                         wb_data;
    logic [CNT_WIDTH-1:0]                          stall_cycles;
    logic                                          stall_cnt_clr;

    modport master (
        output advance, flush,
        output issue_valid, issue_addr, issue_data, issue_data_valid,
        output resolve_valid, resolve_data,
        output rd_addr, rd_reg_data, stall_cnt_clr,
        input  rd_data, rd_stall, stall,
        input  wb_we, wb_addr, wb_data, stall_cycles
    );

    modport slave (
        input  advance, flush,
        input  issue_valid, issue_addr, issue_data, issue_data_valid,
        input  resolve_valid, resolve_data,
        input  rd_addr, rd_reg_data, stall_cnt_clr,
        output rd_data, rd_stall, stall,
        output wb_we, wb_addr, wb_data, stall_cycles
    );

endinterface

// File: rtl/fwd_scoreboard_port_lookup.sv
// fwd_port_lookup
//   Combinational operand resolution for one decode read port.
//   Searches all slots, youngest (slot 0) wins, with a same-cycle bypass of
//   resolve_data when the winning entry sits in RESOLVE_STAGE.
//   Ports:
//     rd_addr / rd_reg_data        : source register and register-file value
//     slot_occ/addr/data/dv        : flattened slot state, index 0 youngest
//     resolve_valid / resolve_data : late data arriving this cycle
//     rd_data / rd_stall           : forwarded operand and pending flag
module fwd_port_lookup
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int RESOLVE_STAGE = 1
) (
    input  logic [ADDR_WIDTH-1:0]                  rd_addr,
    input  logic [DATA_WIDTH-1:0]                  rd_reg_data,
    input  logic [NUM_STAGES-1:0]                  slot_occ,
    input  logic [NUM_STAGES-1:0]                  slot_dv,
    input  logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0]  slot_addr,
    input  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0]  slot_data,
    input  logic                                   resolve_valid,
    input  logic [DATA_WIDTH-1:0]                  resolve_data,
    output logic [DATA_WIDTH-1:0]                  rd_data,
    output logic                                   rd_stall
);

    fwd_lookup_e           kind;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  addr_zero;

    assign addr_zero = (rd_addr == '0);

    // Walk oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        kind     = LK_MISS;
        hit_data = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!addr_zero && slot_occ[i] && slot_addr[i] == rd_addr) begin
                if (slot_dv[i]) begin
                    kind     = LK_HIT;
                    hit_data = slot_data[i];
                end else if (i == RESOLVE_STAGE && resolve_valid) begin
                    kind     = LK_BYPASS;
                    hit_data = resolve_data;
                end else begin
                    kind     = LK_PEND;
                    hit_data = '0;
                end
            end
        end
    end

    always_comb begin
        rd_stall = (kind == LK_PEND);
        if (addr_zero)
            rd_data = '0;
        else if (kind == LK_HIT || kind == LK_BYPASS)
            rd_data = hit_data;
        else
            rd_data = rd_reg_data;
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Shifting N-slot tag pipeline tracking in-flight register writes.
//   Supplies forwarded operands / stalls to decode, resolves late (load)
//   data in place, and drives the register-file write port from the oldest
//   slot.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : fwd_scoreboard_if.slave (issue, resolve, read ports,
//                writeback, stall counter)
//   RESOLVE_STAGE must be < NUM_STAGES-1 so a resolved entry can always
//   move one slot further before it reaches writeback.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int RESOLVE_STAGE  = 1,
    parameter int FLUSH_STAGES   = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    fwd_scoreboard_if.slave  bus
);

    localparam int LAST = NUM_STAGES - 1;

    typedef struct packed {
        logic                  occupied;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  data_valid;
    } slot_t;

    slot_t slot_q [NUM_STAGES];
    slot_t slot_d [NUM_STAGES];

    logic [NUM_STAGES-1:0]                 s_occ;
    logic [NUM_STAGES-1:0]                 s_dv;
    logic [NUM_STAGES-1:0][ADDR_WIDTH-1:0] s_addr;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] s_data;

    logic [CNT_WIDTH-1:0] stall_cnt;

    // ---------------- next slot state ----------------
    // Order: shift (or hold), then resolve on the entry that was in
    // RESOLVE_STAGE (wherever it now sits), then flush of the youngest slots.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++)
            slot_d[i] = slot_q[i];

        if (bus.advance) begin
            slot_d[0] = '{occupied:   bus.issue_valid,
                          addr:       bus.issue_addr,
                          data:       bus.issue_data,
                          data_valid: bus.issue_data_valid};
            for (int i = 1; i < NUM_STAGES; i++)
                slot_d[i] = slot_q[i-1];
        end

        if (bus.resolve_valid && slot_q[RESOLVE_STAGE].occupied) begin
            if (bus.advance) begin
                slot_d[RESOLVE_STAGE+1].data       = bus.resolve_data;
                slot_d[RESOLVE_STAGE+1].data_valid = 1'b1;
            end else begin
                slot_d[RESOLVE_STAGE].data       = bus.resolve_data;
                slot_d[RESOLVE_STAGE].data_valid = 1'b1;
            end
        end

        // Flush wins over the instruction issued in the same cycle.
        if (bus.flush) begin
            for (int i = 0; i < FLUSH_STAGES; i++)
                slot_d[i].occupied = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++)
                slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++)
                slot_q[i] <= slot_d[i];
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            s_occ[i]  = slot_q[i].occupied;
            s_dv[i]   = slot_q[i].data_valid;
            s_addr[i] = slot_q[i].addr;
            s_data[i] = slot_q[i].data;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_READ_PORTS; p++) begin : g_port
            fwd_port_lookup #(
                .NUM_STAGES    (NUM_STAGES),
                .DATA_WIDTH    (DATA_WIDTH),
                .ADDR_WIDTH    (ADDR_WIDTH),
                .RESOLVE_STAGE (RESOLVE_STAGE)
            ) u_lookup (
                .rd_addr       (bus.rd_addr[p]),
                .rd_reg_data   (bus.rd_reg_data[p]),
                .slot_occ      (s_occ),
                .slot_dv       (s_dv),
                .slot_addr     (s_addr),
                .slot_data     (s_data),
                .resolve_valid (bus.resolve_valid),
                .resolve_data  (bus.resolve_data),
                .rd_data       (bus.rd_data[p]),
                .rd_stall      (bus.rd_stall[p])
            );
        end
    endgenerate

    assign bus.stall = |bus.rd_stall;

    // ---------------- writeback ----------------
    assign bus.wb_we   = slot_q[LAST].occupied & slot_q[LAST].data_valid & bus.advance;
    assign bus.wb_addr = slot_q[LAST].addr;
    assign bus.wb_data = slot_q[LAST].data;

    // An unresolved writer must never leave the pipeline.
    a_no_unresolved_retire : assert property (
        @(posedge clk) disable iff (rst)
        !(bus.advance && slot_q[LAST].occupied && !slot_q[LAST].data_valid));

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.stall_cnt_clr)
            stall_cnt <= '0;
        else if (bus.stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_cycles = stall_cnt;

endmodule
